// File: rtl/store_trace_fifo.sv
// Trace FIFO that records every data-memory store {PC, address, data, byte mask}
// and lets a consumer drain them show-ahead over valid/ready; overflow drops are counted.
module store_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic [31:0]              PC,
  input  logic                     MemWrite,
  input  logic [3:0]               MemWriteSelect,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_addr,
  output logic [31:0]              trace_data,
  output logic [3:0]               trace_mask,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 100;

  logic [RW-1:0]     r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  logic              w_push_req;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [RW-1:0]     w_head;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A zero byte mask is not a real store and is neither captured nor counted.
  assign w_push_req = capture_en & MemWrite & (|MemWriteSelect);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = trace_ready & ~w_empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= sat_inc(r_drop_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear)
      r_mem[r_wr_ptr[AW-1:0]] <= {PC, DataAdr, WriteData, MemWriteSelect};
  end

  assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign trace_valid = ~w_empty;
  assign trace_pc    = w_head[99:68];
  assign trace_addr  = w_head[67:36];
  assign trace_data  = w_head[35:4];
  assign trace_mask  = w_head[3:0];
  assign count       = r_wr_ptr - r_rd_ptr;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Scoreboard bench for store_trace_fifo: stimulus queues expected records,
// a negedge monitor compares every popped head against the queue.
module tb_store_trace_fifo;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              capture_en = 1'b1;
  logic              clear = 1'b0;
  logic [31:0]       PC = '0;
  logic              MemWrite = 1'b0;
  logic [3:0]        MemWriteSelect = '0;
  logic [31:0]       DataAdr = '0;
  logic [31:0]       WriteData = '0;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [31:0]       trace_pc, trace_addr, trace_data;
  logic [3:0]        trace_mask;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  logic [99:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  store_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .clear(clear),
    .PC(PC), .MemWrite(MemWrite), .MemWriteSelect(MemWriteSelect),
    .DataAdr(DataAdr), .WriteData(WriteData),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_mask(trace_mask), .count(count), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the coming posedge whenever valid & ready now.
  always @(negedge clk) begin
    if (!reset && trace_valid && trace_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got pc 0x%0h expected no record", trace_pc);
      end else begin
        if ({trace_pc, trace_addr, trace_data, trace_mask} !== exp_q[0]) begin
          n_bad++;
          $display("FAIL pop_record: got %h expected %h",
                   {trace_pc, trace_addr, trace_data, trace_mask}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one store for one cycle; expect_push says whether the bench expects it stored.
  task automatic store(input logic [31:0] pc, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] m,
                       input bit expect_push);
    PC = pc; DataAdr = adr; WriteData = dat; MemWriteSelect = m; MemWrite = 1'b1;
    if (expect_push) exp_q.push_back({pc, adr, dat, m});
    tick();
    MemWrite = 1'b0; MemWriteSelect = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_valid", {31'd0, trace_valid}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_pc", trace_pc, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: single sw shows up immediately after the write edge
    store(32'h0000_0010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    chk("t1_valid", {31'd0, trace_valid}, 32'd1);
    chk("t1_count", {27'd0, count}, 32'd1);
    chk("t1_pc", trace_pc, 32'h0000_0010);
    chk("t1_addr", trace_addr, 32'h100);
    chk("t1_data", trace_data, 32'hDEAD_BEEF);
    chk("t1_mask", {28'd0, trace_mask}, 32'hF);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    chk("t1_drained", {27'd0, count}, 32'd0);

    // 2: sb then sh, drained in order
    store(32'h0000_0020, 32'h104, 32'h0000_5A00, 4'b0100, 1'b1);
    store(32'h0000_0024, 32'h108, 32'h0000_1234, 4'b0011, 1'b1);
    chk("t2_count2", {27'd0, count}, 32'd2);
    trace_ready = 1'b1;
    tick();
    tick();
    trace_ready = 1'b0;
    chk("t2_count0", {27'd0, count}, 32'd0);
    chk("t2_valid0", {31'd0, trace_valid}, 32'd0);

    // 3: overfill by three
    for (int i = 0; i < DEPTH + 3; i++)
      store(32'h1000 + 32'(i) * 4, 32'h200 + 32'(i) * 4, 32'hA500_0000 + 32'(i),
            4'b1111, i < DEPTH);
    chk("t3_count", {27'd0, count}, DEPTH);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_drops", {16'd0, drop_count}, 32'd3);
    chk("t3_head_pc", trace_pc, 32'h1000);

    // 4: push and pop together while full
    trace_ready = 1'b1;
    store(32'h0000_BEE0, 32'h3FC, 32'hCAFE_F00D, 4'b1100, 1'b1);
    trace_ready = 1'b0;
    chk("t4_count", {27'd0, count}, DEPTH);
    chk("t4_drops", {16'd0, drop_count}, 32'd3);
    chk("t4_head_pc", trace_pc, 32'h1004);
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    trace_ready = 1'b0;
    chk("t4_count0", {27'd0, count}, 32'd0);
    do_clear();
    chk("clr_overflow", {31'd0, overflow}, 32'd0);

    // 5: non-stores
    store(32'h50, 32'h500, 32'h1111_1111, 4'b0000, 1'b0);
    capture_en = 1'b0;
    store(32'h54, 32'h504, 32'h2222_2222, 4'b1111, 1'b0);
    capture_en = 1'b1;
    chk("t5_count", {27'd0, count}, 32'd0);
    chk("t5_drops", {16'd0, drop_count}, 32'd0);

    // 6: async reset mid-cycle, then clear with a concurrent push
    for (int i = 0; i < 5; i++)
      store(32'h6000 + 32'(i) * 4, 32'h600 + 32'(i), 32'h6600_0000 + 32'(i), 4'b0001, 1'b1);
    chk("t6_count5", {27'd0, count}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_rst_valid", {31'd0, trace_valid}, 32'd0);
    chk("t6_rst_count", {27'd0, count}, 32'd0);
    chk("t6_rst_pc", trace_pc, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      store(32'h7000 + 32'(i) * 4, 32'h700, 32'h7700_0000 + 32'(i), 4'b1000, i < DEPTH);
    chk("t6_overflow", {31'd0, overflow}, 32'd1);
    chk("t6_drops", {16'd0, drop_count}, 32'd1);
    clear = 1'b1;
    store(32'h8000, 32'h800, 32'h8888_8888, 4'b1111, 1'b0);
    clear = 1'b0;
    exp_q.delete();
    chk("t6_clr_count", {27'd0, count}, 32'd0);
    chk("t6_clr_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_clr_drops", {16'd0, drop_count}, 32'd0);
    chk("t6_clr_valid", {31'd0, trace_valid}, 32'd0);
    tick();
    chk("sb_left", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
